// File: rtl/miscv_pkg.sv
// Shared types for the MISC-V core pipeline stages.
// No logic; constants and types only.
// Contents: writeback-source encodings, memory FSM state type, EX/MEM payload struct.
package miscv_pkg;

  // Writeback source select (RegStore field)
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC   = 2'b10;
  localparam logic [1:0] WB_ZERO = 2'b11;

  // Data-memory access FSM
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // EX/MEM pipeline register payload
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  reg_store;
    logic [15:0] pcp2;
    logic [15:0] alu_result;
    logic [15:0] third_arg;
    logic [2:0]  rd;
  } exmem_t;

endpackage

// File: rtl/memory_stage_ex_mem.sv
// EX/MEM pipeline register with hold enable.
// One cycle latency; when hold=1 the contents are frozen.
// Ports: clk, reset (async, active-high), hold, d (next payload), q (registered payload).
module EX_MEM
  import miscv_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  exmem_t d,
  output exmem_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mux16b4.sv
// 4:1 multiplexer, 16-bit wide.
// Purely combinational, zero latency; no flow control.
// Ports: in0..in3 data inputs, sel select, out selected value.
module mux16b4 (
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  input  logic [1:0]  sel,
  output logic [15:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      2'b00:   out = in0;
      2'b01:   out = in1;
      2'b10:   out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: EX/MEM register, variable-latency data-memory handshake, MEM/WB register.
// Latency 1 cycle for non-memory ops; memory ops add k cycles (k = wait cycles, capped at TIMEOUT).
// Backpressure: Stall freezes upstream while an access is outstanding; MEM/WB takes bubbles meanwhile.
// Ports: I* from execute; mem_* data-memory port; Stall upstream freeze; *MEM forwarding taps;
//        O* MEM/WB contents; loadDataWB selected writeback value; OMemErr sticky timeout flag.
module memory_stage
  import miscv_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRegWrite,
  input  logic        IMemWrite,
  input  logic        IMemRead,
  input  logic [1:0]  IRegStore,
  input  logic [15:0] IPCP2,
  input  logic [15:0] IALUResult,
  input  logic [15:0] I3rdArg,
  input  logic [2:0]  IRd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        Stall,
  output logic [15:0] ALUResultMEM,
  output logic [2:0]  RdMEM,
  output logic        RegWriteMEM,
  output logic        ORegWrite,
  output logic [1:0]  ORegStore,
  output logic [2:0]  ORd,
  output logic [15:0] OPCP2,
  output logic [15:0] OALUResult,
  output logic [15:0] OLoadData,
  output logic [15:0] loadDataWB,
  output logic        OMemErr
);

  // Counter only needs to reach TIMEOUT-1
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  exmem_t     ex_d;
  exmem_t     ex_q;
  mem_state_t state;
  mem_state_t state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic memop;
  logic rd_op;
  logic done;
  logic timeout_hit;

  // ---------------- EX/MEM register ----------------
  always_comb begin
    ex_d            = '0;
    ex_d.reg_write  = IRegWrite;
    ex_d.mem_write  = IMemWrite;
    ex_d.mem_read   = IMemRead;
    ex_d.reg_store  = IRegStore;
    ex_d.pcp2       = IPCP2;
    ex_d.alu_result = IALUResult;
    ex_d.third_arg  = I3rdArg;
    ex_d.rd         = IRd;
  end

  EX_MEM u_ex_mem (
    .clk   (clk),
    .reset (reset),
    .hold  (Stall),
    .d     (ex_d),
    .q     (ex_q)
  );

  assign memop = ex_q.mem_read | ex_q.mem_write;
  // Write wins when both control bits are set
  assign rd_op = ex_q.mem_read & ~ex_q.mem_write;

  // The EX/MEM register reloads on the edge an access ends, so a held
  // memop is always the current, not-yet-finished access.
  assign mem_req      = memop;
  assign mem_we       = ex_q.mem_write;
  assign mem_addr     = ex_q.alu_result;
  assign mem_wdata    = ex_q.third_arg;

  assign ALUResultMEM = ex_q.alu_result;
  assign RdMEM        = ex_q.rd;
  assign RegWriteMEM  = ex_q.reg_write;

  // ---------------- access FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    done        = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          if (mem_ready) begin
            done = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = '0;
          end
        end
      end
      WAIT: begin
        if (!memop) begin
          state_nx = IDLE;
        end else if (mem_ready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          // Give up: release the pipeline and flag the error
          timeout_hit = 1'b1;
          state_nx    = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign Stall = memop & ~mem_ready & ~timeout_hit;

  // ---------------- MEM/WB register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ORegWrite  <= 1'b0;
      ORegStore  <= WB_ALU;
      ORd        <= '0;
      OPCP2      <= '0;
      OALUResult <= '0;
      OLoadData  <= '0;
      OMemErr    <= 1'b0;
    end else begin
      if (Stall) begin
        // Bubble: only the write enable is killed, the rest holds
        ORegWrite <= 1'b0;
      end else begin
        ORegWrite  <= ex_q.reg_write;
        ORegStore  <= ex_q.reg_store;
        ORd        <= ex_q.rd;
        OPCP2      <= ex_q.pcp2;
        OALUResult <= ex_q.alu_result;
        if (done && rd_op) begin
          OLoadData <= mem_rdata;
        end else if (timeout_hit) begin
          OLoadData <= '0;
        end
      end
      if (timeout_hit) begin
        OMemErr <= 1'b1;
      end
    end
  end

  mux16b4 u_wb_mux (
    .in0 (OALUResult),
    .in1 (OLoadData),
    .in2 (OPCP2),
    .in3 (16'h0000),
    .sel (ORegStore),
    .out (loadDataWB)
  );

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth pipeline stage of the 16-bit MISC-V core. It sits between the execute stage and register writeback. It owns the EX/MEM pipeline register, drives a variable-latency data-memory port through a req/ready handshake, stalls the upstream pipeline while an access is outstanding, and owns the MEM/WB register. It returns the two forwarding values the execute stage consumes: `ALUResultMEM` and `loadDataWB`.

## Interface
- `TIMEOUT`, default 15: maximum number of WAIT cycles before an access is abandoned.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `IRegWrite`, `IMemWrite`, `IMemRead` in 1 each: control bits from the execute stage.
- `IRegStore` in 2: writeback source select.
- `IPCP2`, `IALUResult`, `I3rdArg` in 16 each: PC+2, ALU result (also the memory address), and store data.
- `IRd` in 3: destination register.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 16, `mem_wdata` out 16: data-memory request.
- `mem_rdata` in 16, `mem_ready` in 1: data-memory response.
- `Stall` out 1: freezes the PC, IF/ID and ID/EX registers.
- `ALUResultMEM` out 16, `RdMEM` out 3, `RegWriteMEM` out 1: EX/MEM contents for forwarding and hazard logic.
- `ORegWrite` out 1, `ORegStore` out 2, `ORd` out 3: MEM/WB control.
- `OPCP2`, `OALUResult`, `OLoadData` out 16 each: MEM/WB data.
- `loadDataWB` out 16: selected writeback value, also forwarded.
- `OMemErr` out 1: sticky timeout flag.

## Operation
- **EX/MEM register:** captures all `I*` inputs on a rising edge when `Stall`=0. It holds its contents when `Stall`=1.
- **Memory operation:** `memop` = EX/MEM `MemRead | MemWrite`. If both bits are set, the access is a write.
- **Request outputs:**
  - `mem_req` = `memop` while not completed.
  - `mem_addr` = EX/MEM ALU result, `mem_wdata` = EX/MEM 3rd arg, `mem_we` = EX/MEM `MemWrite`.
  - All are combinational from the register and state, and stable while `mem_req`=1.
- **FSM states:**
  - IDLE:
    - `memop` with `mem_ready`=1: zero-wait completion, stay in IDLE.
    - `memop` with `mem_ready`=0: go to WAIT and clear the wait counter.
  - WAIT:
    - `mem_ready`=1: complete and go to IDLE.
    - Otherwise: increment the counter.
    - Counter == `TIMEOUT`-1 without ready: abandon the access, set `OMemErr`, load data = 16'h0000, go to IDLE.
- **Stall:** `Stall` = `memop` & ~`mem_ready` & ~`timeout_hit`. `Stall` is combinational.
- **MEM/WB register:** updates every edge.
  - When `Stall`=0, it captures RegWrite, RegStore, Rd, PCP2 and ALUResult from EX/MEM. `OLoadData` takes `mem_rdata` on a completed read and is otherwise held.
  - When `Stall`=1, it inserts a bubble: `ORegWrite`=0, and the other MEM/WB fields hold.
- **Writeback select:** `loadDataWB` by `ORegStore`: 00 = `OALUResult`, 01 = `OLoadData`, 10 = `OPCP2`, 11 = 16'h0000.
- **OMemErr:** sticky until `reset`.

## Timing
- **Reset:** all registers clear to 0, FSM goes to IDLE.
- **Outputs during reset:**
  - All outputs are 0 while `reset` is high, including `mem_req`, `Stall` and `OMemErr`.
  - `reset` during WAIT drops `mem_req` immediately (asynchronous) and discards the access.
- **Non-memory instruction:** 1 cycle EX/MEM → MEM/WB, no stall.
- **Memory access:** with `mem_ready` first seen in the cycle *k* cycles after the request (k=0 is zero-wait), the instruction stalls *k* cycles. MEM/WB receives the result on the edge closing cycle *k*.
- **Abandoned access:** stalls exactly `TIMEOUT` cycles.
- **Back-to-back memops:** the next request begins the cycle after completion. The same address/data is never re-requested.
- **`mem_ready` with `mem_req`=0:** ignored.
- **Write completion:** leaves `OLoadData` unchanged.

## Structure
- **Shared package `miscv_pkg`:**
  - RegStore encodings WB_ALU=2'b00, WB_LOAD=2'b01, WB_PC=2'b10, WB_ZERO=2'b11.
  - FSM state type {IDLE, WAIT}.
- **Sub-module `EX_MEM`:** pipeline register with a hold enable, structured like the existing ID_EX.
- **`memory_stage`:** instantiates `EX_MEM` and contains the FSM, counter and MEM/WB register.
- **Writeback mux:** reuse `mux16b4`.

## Test plan
- **ALU op pass-through:** ALU op `IALUResult`=16'h1234, RegStore=00, Rd=5 → next cycle `ALUResultMEM`=1234, `RdMEM`=5. One cycle later `loadDataWB`=1234, `ORd`=5, `ORegWrite`=1, `Stall` never high.
- **Zero-wait load:** load addr 16'h0040, memory returns 16'hBEEF with `mem_ready`=1 in the same cycle → `mem_req` for 1 cycle, `mem_we`=0, no stall, then `loadDataWB`=BEEF with RegStore=01.
- **3-wait store:** store addr 16'h0010, data 16'hCAFE, ready after 3 cycles → `Stall` high 3 cycles, `mem_we`=1, addr/wdata stable throughout. MEM/WB shows `ORegWrite`=0 bubbles during the stall, and `OLoadData` is unchanged.
- **Timeout:** `mem_ready` held 0 on a load → `Stall` high exactly 15 cycles, `OMemErr`=1 and stays 1, `OLoadData`=0000, pipeline resumes.
- **Reset mid-WAIT:** assert `reset` mid-WAIT → `mem_req`, `Stall`, `ORegWrite` = 0 immediately. After release, the FSM is in IDLE and a fresh ALU op flows normally.
- **Load then ALU op:** load (2 waits) immediately followed by an ALU op → the ALU op is held in EX until the load completes, then enters EX/MEM the following edge.
